// File: rtl/serial_adder32.sv
// Serial ripple-carry adder: op1 + op2 + cin, STEP bits per clock, start/done handshake.
// Latency WIDTH/STEP+1 clocks from accepted start to done; start ignored while busy. OVERFLOW_EN enables ovf.
// No backpressure: result held in res until the next completed operation.
module serial_adder32 #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4     // must divide WIDTH exactly
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / STEP;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q, res_q;
    logic             carry_q, cout_q, done_q;
    logic [CW-1:0]    cnt;

    logic [STEP:0]    chunk;
    logic [WIDTH-1:0] sum_full;
    logic             last;

    // Current chunk sum, and the working sum with this chunk merged in.
    always_comb begin
        chunk    = {1'b0, a_q[cnt*STEP +: STEP]} + {1'b0, b_q[cnt*STEP +: STEP]}
                 + {{STEP{1'b0}}, carry_q};
        sum_full = sum_q;
        sum_full[cnt*STEP +: STEP] = chunk[STEP-1:0];
        last     = (cnt == CW'(NCHUNK - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = done_q;
        res  = res_q;
        cout = cout_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= op1;
                        b_q     <= op2;
                        carry_q <= cin;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_full;
                    carry_q <= chunk[STEP];
                    cnt     <= cnt + 1'b1;
                    // Architectural outputs move only here, never mid-operation.
                    if (last) begin
                        res_q  <= sum_full;
                        cout_q <= chunk[STEP];
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
